// File: rtl/snn_pkg.sv
// Shared definitions for the spiking output layer: FSM encoding, sizes,
// and the index-to-one-hot decode used by the winner-take-all controller.
package snn_pkg;

  localparam int unsigned P_WIDTH_DEF = 19;
  localparam int unsigned N_NEURONS   = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_DECIDE  = 3'd2,
    S_FIRE    = 3'd3,
    S_INHIBIT = 3'd4,
    S_REFRACT = 3'd5,
    S_DONE    = 3'd6
  } wta_state_t;

  function automatic logic [N_NEURONS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_NEURONS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wta_controller_if.sv
// Spike offer channel from the winner-take-all controller to the consumer.
//   o_spike_valid  : spike offer pending (controller -> consumer)
//   i_spike_ready  : consumer accepts spike (consumer -> controller)
//   o_spike_onehot : winning neuron, one-hot
//   o_spike_value  : winning membrane potential
interface wta_controller_if #(
  parameter int unsigned P_WIDTH = snn_pkg::P_WIDTH_DEF
) ();

  logic                           o_spike_valid;
  logic                           i_spike_ready;
  logic [snn_pkg::N_NEURONS-1:0]  o_spike_onehot;
  logic [P_WIDTH-1:0]             o_spike_value;

  modport master (
    output o_spike_valid,
    output o_spike_onehot,
    output o_spike_value,
    input  i_spike_ready
  );

  modport slave (
    input  o_spike_valid,
    input  o_spike_onehot,
    input  o_spike_value,
    output i_spike_ready
  );

endinterface

// File: rtl/wta_max8.sv
// Combinational 8-to-1 maximum finder with lowest-index tie-break.
//   i_potential : packed potentials, neuron n at [n*P_WIDTH +: P_WIDTH]
//   o_max_val   : largest potential
//   o_max_idx   : index of the largest potential (lowest index on ties)
module wta_max8 import snn_pkg::*; #(
  parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
  input  logic [N_NEURONS*P_WIDTH-1:0] i_potential,
  output logic [P_WIDTH-1:0]           o_max_val,
  output logic [IDX_W-1:0]             o_max_idx
);

  logic [P_WIDTH-1:0] w_v     [N_NEURONS];
  logic [P_WIDTH-1:0] w_p_val [4];
  logic [IDX_W-1:0]   w_p_idx [4];
  logic [P_WIDTH-1:0] w_q_val [2];
  logic [IDX_W-1:0]   w_q_idx [2];

  // Each stage keeps the lower-indexed candidate unless the upper one is strictly larger.
  always_comb begin
    for (int n = 0; n < int'(N_NEURONS); n++) begin
      w_v[n] = i_potential[n*P_WIDTH +: P_WIDTH];
    end
    for (int k = 0; k < 4; k++) begin
      if (w_v[2*k+1] > w_v[2*k]) begin
        w_p_val[k] = w_v[2*k+1];
        w_p_idx[k] = IDX_W'(2*k+1);
      end else begin
        w_p_val[k] = w_v[2*k];
        w_p_idx[k] = IDX_W'(2*k);
      end
    end
    for (int q = 0; q < 2; q++) begin
      if (w_p_val[2*q+1] > w_p_val[2*q]) begin
        w_q_val[q] = w_p_val[2*q+1];
        w_q_idx[q] = w_p_idx[2*q+1];
      end else begin
        w_q_val[q] = w_p_val[2*q];
        w_q_idx[q] = w_p_idx[2*q];
      end
    end
    if (w_q_val[1] > w_q_val[0]) begin
      o_max_val = w_q_val[1];
      o_max_idx = w_q_idx[1];
    end else begin
      o_max_val = w_q_val[0];
      o_max_idx = w_q_idx[0];
    end
  end

endmodule

// File: rtl/wta_controller.sv
// Winner-take-all sequencer for the 8-neuron output layer. Captures the
// potentials on a timestep strobe, finds the winner, offers a one-hot spike
// if it reaches threshold, pulses inhibition, then holds a refractory window.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_step         : one-cycle timestep strobe
//   i_potential    : packed membrane potentials
//   i_threshold    : firing threshold (unsigned)
//   spike_if       : spike valid/ready channel (master side)
//   o_busy         : not IDLE
//   o_inhibit      : one-cycle lateral inhibition pulse
//   o_refractory   : in refractory window
//   o_step_done    : one-cycle pulse, timestep handled
//   o_overrun      : sticky, timestep arrived while evaluating
module wta_controller import snn_pkg::*; #(
  parameter int unsigned P_WIDTH   = P_WIDTH_DEF,
  parameter int unsigned P_REFRACT = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_step,
  input  logic [N_NEURONS*P_WIDTH-1:0] i_potential,
  input  logic [P_WIDTH-1:0]           i_threshold,
  wta_controller_if.master             spike_if,
  output logic                         o_busy,
  output logic                         o_inhibit,
  output logic                         o_refractory,
  output logic                         o_step_done,
  output logic                         o_overrun
);

  wta_state_t                   r_state, w_next;
  logic [N_NEURONS*P_WIDTH-1:0] r_pot;
  logic [P_WIDTH-1:0]           r_thr;
  logic [P_WIDTH-1:0]           r_max_val;
  logic [IDX_W-1:0]             r_max_idx;
  logic [CNT_W-1:0]             r_cnt, w_cnt_next;
  logic                         r_spike_valid, r_busy, r_inhibit, r_refr, r_step_done, r_overrun;
  logic [N_NEURONS-1:0]         r_onehot;
  logic [P_WIDTH-1:0]           r_value;
  logic                         w_overrun_set, w_step_done_d;
  logic [P_WIDTH-1:0]           w_max_val;
  logic [IDX_W-1:0]             w_max_idx;

  wta_max8 #(.P_WIDTH(P_WIDTH)) u_max8 (
    .i_potential (r_pot),
    .o_max_val   (w_max_val),
    .o_max_idx   (w_max_idx)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state, counter and event logic
  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_overrun_set = 1'b0;
    w_step_done_d = 1'b0;
    unique case (r_state)
      S_IDLE:    if (i_step) w_next = S_COMPARE;
      S_COMPARE: begin
        w_overrun_set = i_step;
        w_next        = S_DECIDE;
      end
      S_DECIDE:  begin
        w_overrun_set = i_step;
        w_next        = (r_max_val >= r_thr) ? S_FIRE : S_DONE;
      end
      S_FIRE:    begin
        w_overrun_set = i_step;
        if (spike_if.i_spike_ready) w_next = S_INHIBIT;
      end
      S_INHIBIT: begin
        w_overrun_set = i_step;
        w_cnt_next    = CNT_W'(P_REFRACT);
        w_next        = (P_REFRACT != 0) ? S_REFRACT : S_DONE;
      end
      S_REFRACT: begin
        // Steps inside the window are swallowed but still acknowledged.
        if (i_step) begin
          w_step_done_d = 1'b1;
          w_cnt_next    = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_next = S_IDLE;
        end
      end
      S_DONE:    begin
        w_overrun_set = i_step;
        w_next        = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
    if (w_next == S_DONE) w_step_done_d = 1'b1;
  end

  // Datapath capture and registered outputs, all derived from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pot         <= '0;
      r_thr         <= '0;
      r_max_val     <= '0;
      r_max_idx     <= '0;
      r_cnt         <= '0;
      r_spike_valid <= 1'b0;
      r_onehot      <= '0;
      r_value       <= '0;
      r_busy        <= 1'b0;
      r_inhibit     <= 1'b0;
      r_refr        <= 1'b0;
      r_step_done   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_step) begin
        r_pot <= i_potential;
        r_thr <= i_threshold;
      end
      if (r_state == S_COMPARE) begin
        r_max_val <= w_max_val;
        r_max_idx <= w_max_idx;
      end
      r_cnt         <= w_cnt_next;
      r_spike_valid <= (w_next == S_FIRE);
      r_onehot      <= (w_next == S_FIRE) ? idx_to_onehot(r_max_idx) : '0;
      r_value       <= (w_next == S_FIRE) ? r_max_val : '0;
      r_busy        <= (w_next != S_IDLE);
      r_inhibit     <= (w_next == S_INHIBIT);
      r_refr        <= (w_next == S_REFRACT);
      r_step_done   <= w_step_done_d;
      r_overrun     <= r_overrun | w_overrun_set;
    end
  end

  assign spike_if.o_spike_valid  = r_spike_valid;
  assign spike_if.o_spike_onehot = r_onehot;
  assign spike_if.o_spike_value  = r_value;
  assign o_busy       = r_busy;
  assign o_inhibit    = r_inhibit;
  assign o_refractory = r_refr;
  assign o_step_done  = r_step_done;
  assign o_overrun    = r_overrun;

endmodule
